uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter_pkg.sv | 19 +
 rtl/uart_tx_arbiter_if.sv | 25 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 147 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the round-robin UART transmit arbiter.
// The optional watchdog is enabled by defining UART_ARB_TIMEOUT_EN.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        SEND  = 2'd2,
        GAP   = 2'd3
    } arb_state_t;

    localparam int DEFAULT_DATA_W = 8;

    // Counter/index width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and serializer handshake bundle for uart_tx_arbiter.
// The slave modport is the arbiter view; master is the surrounding system.
interface uart_tx_arbiter_if
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DEFAULT_DATA_W
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      tx_wr_en;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_wr_done;

    modport master (
        output req_valid, req_data, tx_wr_done,
        input  req_ready, tx_wr_en, tx_data
    );

    modport slave (
        input  req_valid, req_data, tx_wr_done,
        output req_ready, tx_wr_en, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr,
// wrapping modulo NUM_REQ.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               found,
    output logic [IDX_W-1:0]   winner
);

    function automatic int wrap(input int v);
        return (v >= NUM_REQ) ? v - NUM_REQ : v;
    endfunction

    // Scan from the far end back toward ptr so the closest candidate wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[IDX_W'(wrap(int'(ptr) + k))]) begin
                found  = 1'b1;
                winner = IDX_W'(wrap(int'(ptr) + k));
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte producers.
// Define UART_ARB_TIMEOUT_EN to add a SEND watchdog that drops stuck bytes.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = DEFAULT_DATA_W,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int IDX_W         = idx_w(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_arbiter_if.slave     bus,
    output logic                 busy,
    output logic [IDX_W-1:0]     grant_id,
    output logic                 err_timeout
);

    localparam int GAP_W = idx_w(GAP_CYCLES + 1);

    arb_state_t          state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                wr_en_q, wr_en_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [NUM_REQ-1:0]  ready_q, ready_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic                busy_q;
    logic                found;
    logic [IDX_W-1:0]    winner;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int WD_W = idx_w(TIMEOUT_CYCLES);
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                err_q, err_d;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req     (bus.req_valid),
        .ptr     (ptr_q),
        .found   (found),
        .winner  (winner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gap_q   <= '0;
            wr_en_q <= 1'b0;
            data_q  <= '0;
            ready_q <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            wd_q    <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gap_q   <= gap_d;
            wr_en_q <= wr_en_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            grant_q <= grant_d;
            busy_q  <= (state_d != IDLE);
`ifdef UART_ARB_TIMEOUT_EN
            wd_q    <= wd_d;
            err_q   <= err_d;
`endif
        end
    end

    // tx_wr_done only matters in SEND; everywhere else it is ignored.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gap_d   = gap_q;
        wr_en_d = wr_en_q;
        data_d  = data_q;
        ready_d = '0;
        grant_d = grant_q;
`ifdef UART_ARB_TIMEOUT_EN
        wd_d    = wd_q;
        err_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    data_d  = DATA_W'(bus.req_data >> (int'(winner) * DATA_W));
                    ready_d = NUM_REQ'(1) << winner;
                    grant_d = winner;
                    ptr_d   = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                wr_en_d = 1'b1;
                state_d = SEND;
`ifdef UART_ARB_TIMEOUT_EN
                wd_d    = '0;
`endif
            end
            SEND: begin
                if (bus.tx_wr_done) begin
                    wr_en_d = 1'b0;
                    gap_d   = '0;
                    state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (int'(wd_q) == TIMEOUT_CYCLES - 1) begin
                    wr_en_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            GAP: begin
                if (int'(gap_q) == GAP_CYCLES - 1) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
        endcase
    end

    assign bus.req_ready = ready_q;
    assign bus.tx_wr_en  = wr_en_q;
    assign bus.tx_data   = data_q;
    assign busy          = busy_q;
    assign grant_id      = grant_q;

`ifdef UART_ARB_TIMEOUT_EN
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter and its rr_pick selector.
// Define UART_ARB_TIMEOUT_EN to also exercise the SEND watchdog.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy;
    logic [1:0] grant_id;
    logic       err_timeout;

    logic [3:0] pick_req = '0;
    logic [1:0] pick_ptr = '0;
    logic       pick_found;
    logic [1:0] pick_winner;

    int vectors    = 0;
    int miscompares = 0;
    int rr_order [5] = '{0, 1, 2, 3, 0};

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .DATA_W         (DATA_W),
        .GAP_CYCLES     (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .busy        (busy),
        .grant_id    (grant_id),
        .err_timeout (err_timeout)
    );

    rr_pick #(.NUM_REQ(4), .IDX_W(2)) pick (
        .req    (pick_req),
        .ptr    (pick_ptr),
        .found  (pick_found),
        .winner (pick_winner)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Completes a frame from SEND: wr_done pulse, then the two gap cycles.
    task automatic finish_frame();
        bus.tx_wr_done = 1'b1;
        tick();
        bus.tx_wr_done = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.req_valid  = 4'b1111;
        bus.req_data   = 32'h1122_3344;
        bus.tx_wr_done = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if ({bus.tx_wr_en, busy, err_timeout} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: got wr_en/busy/err=%b required 000",
                     {bus.tx_wr_en, busy, err_timeout});
        end
        vectors++;
        if (bus.req_ready !== 4'b0000 || grant_id !== 2'd0 || bus.tx_data !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_data: got ready=%b grant=%0d data=%h required 0000/0/00",
                     bus.req_ready, grant_id, bus.tx_data);
        end
        rst = 1'b0;
        bus.req_valid  = '0;
        bus.tx_wr_done = 1'b0;
        tick();
    endtask

    task automatic test_rr_pick();
        logic [3:0] reqs    [9] = '{4'b0000, 4'b0001, 4'b1001, 4'b0001, 4'b0110,
                                    4'b1111, 4'b0100, 4'b1000, 4'b0000};
        logic [1:0] ptrs    [9] = '{2'd0, 2'd0, 2'd3, 2'd3, 2'd3, 2'd2, 2'd3, 2'd1, 2'd2};
        logic       founds  [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [1:0] winners [9] = '{2'd0, 2'd0, 2'd3, 2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 9; i++) begin
            pick_req = reqs[i];
            pick_ptr = ptrs[i];
            #1;
            vectors++;
            if (pick_found !== founds[i] || (founds[i] && pick_winner !== winners[i])) begin
                miscompares++;
                $display("[TB] FAIL rr_pick[%0d]: got found=%b winner=%0d required found=%b winner=%0d",
                         i, pick_found, pick_winner, founds[i], winners[i]);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        bus.req_data  = 32'h0000_0069;
        bus.req_valid = 4'b0001;
        tick();
        vectors++;
        if (bus.req_ready !== 4'b0001 || grant_id !== 2'd0 || bus.tx_data !== 8'h69 ||
            bus.tx_wr_en !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL single_grant: got ready=%b grant=%0d data=%h wr_en=%b busy=%b required 0001/0/69/0/1",
                     bus.req_ready, grant_id, bus.tx_data, bus.tx_wr_en, busy);
        end
        bus.req_valid = 4'b0000;
        tick();
        vectors++;
        if (bus.tx_wr_en !== 1'b1 || bus.req_ready !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL single_wr_en: got wr_en=%b ready=%b required 1/0000",
                     bus.tx_wr_en, bus.req_ready);
        end
        for (int i = 1; i < 20; i++) begin
            tick();
            vectors++;
            if (bus.tx_wr_en !== 1'b1 || bus.tx_data !== 8'h69) begin
                miscompares++;
                $display("[TB] FAIL single_hold[%0d]: got wr_en=%b data=%h required 1/69",
                         i, bus.tx_wr_en, bus.tx_data);
            end
        end
        bus.tx_wr_done = 1'b1;
        tick();
        bus.tx_wr_done = 1'b0;
        vectors++;
        if (bus.tx_wr_en !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL single_done: got wr_en=%b busy=%b required 0/1", bus.tx_wr_en, busy);
        end
        tick();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL single_gap2: got busy=%b required 1", busy);
        end
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_idle: got busy=%b required 0", busy);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.req_data  = 32'hA3A2_A1A0;
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (bus.req_ready !== (4'b0001 << rr_order[i]) || grant_id !== 2'(rr_order[i]) ||
                bus.tx_data !== 8'(8'hA0 + rr_order[i])) begin
                miscompares++;
                $display("[TB] FAIL rr_grant[%0d]: got ready=%b grant=%0d data=%h required grant %0d",
                         i, bus.req_ready, grant_id, bus.tx_data, rr_order[i]);
            end
            tick();
            finish_frame();
        end
        bus.req_valid = 4'b0000;
    endtask

    task automatic test_wrap();
        do_reset();
        bus.req_data  = 32'hD3D2_D1D0;
        bus.req_valid = 4'b0100;
        tick();
        bus.req_valid = 4'b0000;
        tick();
        finish_frame();
        bus.req_valid = 4'b1001;
        tick();
        vectors++;
        if (bus.req_ready !== 4'b1000 || grant_id !== 2'd3 || bus.tx_data !== 8'hD3) begin
            miscompares++;
            $display("[TB] FAIL wrap_first: got ready=%b grant=%0d data=%h required 1000/3/d3",
                     bus.req_ready, grant_id, bus.tx_data);
        end
        tick();
        finish_frame();
        tick();
        vectors++;
        if (bus.req_ready !== 4'b0001 || grant_id !== 2'd0 || bus.tx_data !== 8'hD0) begin
            miscompares++;
            $display("[TB] FAIL wrap_second: got ready=%b grant=%0d data=%h required 0001/0/d0",
                     bus.req_ready, grant_id, bus.tx_data);
        end
        bus.req_valid = 4'b0000;
        tick();
        finish_frame();
        bus.req_valid = 4'b0011;
        tick();
        vectors++;
        if (bus.req_ready !== 4'b0010 || grant_id !== 2'd1) begin
            miscompares++;
            $display("[TB] FAIL wrap_ptr: got ready=%b grant=%0d required 0010/1",
                     bus.req_ready, grant_id);
        end
        bus.req_valid = 4'b0000;
        tick();
        finish_frame();
    endtask

    task automatic test_reset_in_send();
        do_reset();
        bus.req_data  = 32'h4433_2211;
        bus.req_valid = 4'b0010;
        tick();
        bus.req_valid = 4'b0000;
        tick();
        vectors++;
        if (bus.tx_wr_en !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rst_send_pre: got wr_en=%b required 1", bus.tx_wr_en);
        end
        rst = 1'b1;
        bus.req_valid = 4'b0100;
        tick();
        vectors++;
        if (bus.tx_wr_en !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd0 ||
            bus.req_ready !== 4'b0000 || bus.tx_data !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL rst_send: got wr_en=%b busy=%b grant=%0d ready=%b data=%h required 0/0/0/0000/00",
                     bus.tx_wr_en, busy, grant_id, bus.req_ready, bus.tx_data);
        end
        rst = 1'b0;
        bus.req_valid = 4'b1010;
        tick();
        vectors++;
        if (bus.req_ready !== 4'b0010 || grant_id !== 2'd1) begin
            miscompares++;
            $display("[TB] FAIL rst_send_ptr: got ready=%b grant=%0d required 0010/1",
                     bus.req_ready, grant_id);
        end
        bus.req_valid = 4'b0000;
        tick();
        finish_frame();
    endtask

    task automatic test_stray_done();
        do_reset();
        bus.req_data   = 32'h5544_3322;
        bus.tx_wr_done = 1'b1;
        tick();
        vectors++;
        if (busy !== 1'b0 || bus.tx_wr_en !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stray_idle: got busy=%b wr_en=%b required 0/0", busy, bus.tx_wr_en);
        end
        bus.tx_wr_done = 1'b0;
        bus.req_valid  = 4'b0100;
        tick();
        bus.req_valid  = 4'b0000;
        bus.tx_wr_done = 1'b1;
        tick();
        vectors++;
        if (bus.tx_wr_en !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL stray_grant: got wr_en=%b busy=%b required 1/1", bus.tx_wr_en, busy);
        end
        bus.tx_wr_done = 1'b0;
        tick();
        vectors++;
        if (bus.tx_wr_en !== 1'b1 || bus.tx_data !== 8'h44) begin
            miscompares++;
            $display("[TB] FAIL stray_send_hold: got wr_en=%b data=%h required 1/44",
                     bus.tx_wr_en, bus.tx_data);
        end
        bus.tx_wr_done = 1'b1;
        tick();
        bus.req_valid = 4'b0001;
        tick();
        vectors++;
        if (busy !== 1'b1 || bus.tx_wr_en !== 1'b0 || bus.req_ready !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL stray_gap: got busy=%b wr_en=%b ready=%b required 1/0/0000",
                     busy, bus.tx_wr_en, bus.req_ready);
        end
        tick();
        bus.tx_wr_done = 1'b0;
        vectors++;
        if (busy !== 1'b0 || bus.req_ready !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL stray_gap_end: got busy=%b ready=%b required 0/0000", busy, bus.req_ready);
        end
        tick();
        vectors++;
        if (bus.req_ready !== 4'b0001 || grant_id !== 2'd0 || bus.tx_data !== 8'h22) begin
            miscompares++;
            $display("[TB] FAIL stray_next: got ready=%b grant=%0d data=%h required 0001/0/22",
                     bus.req_ready, grant_id, bus.tx_data);
        end
        bus.req_valid = 4'b0000;
        tick();
        finish_frame();
    endtask

`ifdef UART_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        bus.req_data  = 32'h0000_B2B1;
        bus.req_valid = 4'b0010;
        tick();
        bus.req_valid = 4'b0001;
        tick();
        for (int i = 1; i < 16; i++) begin
            tick();
            vectors++;
            if (bus.tx_wr_en !== 1'b1 || err_timeout !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL timeout_wait[%0d]: got wr_en=%b err=%b required 1/0",
                         i, bus.tx_wr_en, err_timeout);
            end
        end
        tick();
        vectors++;
        if (bus.tx_wr_en !== 1'b0 || err_timeout !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL timeout_abort: got wr_en=%b err=%b busy=%b required 0/1/0",
                     bus.tx_wr_en, err_timeout, busy);
        end
        tick();
        vectors++;
        if (err_timeout !== 1'b0 || bus.req_ready !== 4'b0001 || bus.tx_data !== 8'hB1) begin
            miscompares++;
            $display("[TB] FAIL timeout_next: got err=%b ready=%b data=%h required 0/0001/b1",
                     err_timeout, bus.req_ready, bus.tx_data);
        end
        bus.req_valid = 4'b0000;
        tick();
        finish_frame();
    endtask
`endif

    initial begin
        bus.req_valid  = '0;
        bus.req_data   = '0;
        bus.tx_wr_done = 1'b0;
        test_reset();
        test_rr_pick();
        test_single();
        test_round_robin();
        test_wrap();
        test_reset_in_send();
        test_stray_done();
`ifdef UART_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL sim_timeout: got no completion required completion within 200000 time units");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

endmodule
